// File: rtl/nios_v2_cpu_debug_slave_cmd_engine_pkg.sv
// Shared constants for the CPU debug slave command engine: IR/op codes, scan-register
// field offsets and the registered action-pulse bundle.
package nios_v2_debug_pkg;

  localparam int unsigned IR_W = 2;

  localparam logic [1:0] IrOcimem    = 2'd0;
  localparam logic [1:0] IrTracemem  = 2'd1;
  localparam logic [1:0] IrBreak     = 2'd2;
  localparam logic [1:0] IrTracectrl = 2'd3;

  localparam logic [1:0] OpBrkA    = 2'd0;
  localparam logic [1:0] OpBrkB    = 2'd1;
  localparam logic [1:0] OpBrkC    = 2'd2;
  localparam logic [1:0] OpIllegal = 2'd3;

  // Field offsets relative to DATA_W within the scan register.
  localparam int unsigned OpOfs  = 4;
  localparam int unsigned ActOfs = 3;
  localparam int unsigned ChOfs  = 0;
  localparam int unsigned ChW    = 3;

  function automatic int unsigned sr_width(int unsigned data_w);
    return data_w + 6;
  endfunction

  typedef struct packed {
    logic ocimem_a;
    logic ocimem_b;
    logic no_ocimem_a;
    logic break_a;
    logic break_b;
    logic break_c;
    logic no_break_a;
    logic no_break_b;
    logic no_break_c;
    logic tracemem;
    logic tracectrl;
  } act_pulse_t;

endpackage

// File: rtl/nios_v2_cpu_debug_slave_cmd_engine_if.sv
// Signal bundle between the debug target/JTAG side (master) and the command engine (slave).
interface nios_v2_cpu_debug_slave_cmd_engine_if
  import nios_v2_debug_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TRACE_W    = 36,
  parameter int unsigned NUM_DBRK   = 4,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned SR_W  = sr_width(DATA_W);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                upd_pulse;
  logic [IR_W-1:0]     upd_ir;
  logic [SR_W-1:0]     upd_sr;
  logic                tgt_ready;
  logic                cap_pulse;
  logic [IR_W-1:0]     cap_ir;
  logic [DATA_W-1:0]   mon_data;
  logic [3:0]          mon_status;
  logic [DATA_W-1:0]   brk_readreg;
  logic [NUM_DBRK-1:0] dbrk_hit;
  logic [TRACE_W-1:0]  trace_data;
  logic [1:0]          trace_stat;

  logic [SR_W-1:0]     jdo;
  logic                take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic                take_action_break_a, take_action_break_b, take_action_break_c;
  logic                take_no_action_break_a, take_no_action_break_b, take_no_action_break_c;
  logic [NUM_DBRK-1:0] brk_ch_sel;
  logic                take_action_tracemem, take_action_tracectrl;
  logic [SR_W-1:0]     cap_sr;
  logic                cap_valid;
  logic [LVL_W-1:0]    fifo_level;
  logic                ovf, cmd_err;

  modport master (
    output upd_pulse, upd_ir, upd_sr, tgt_ready, cap_pulse, cap_ir, mon_data, mon_status,
           brk_readreg, dbrk_hit, trace_data, trace_stat,
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
           take_action_break_a, take_action_break_b, take_action_break_c,
           take_no_action_break_a, take_no_action_break_b, take_no_action_break_c,
           brk_ch_sel, take_action_tracemem, take_action_tracectrl, cap_sr, cap_valid,
           fifo_level, ovf, cmd_err
  );

  modport slave (
    input  upd_pulse, upd_ir, upd_sr, tgt_ready, cap_pulse, cap_ir, mon_data, mon_status,
           brk_readreg, dbrk_hit, trace_data, trace_stat,
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
           take_action_break_a, take_action_break_b, take_action_break_c,
           take_no_action_break_a, take_no_action_break_b, take_no_action_break_c,
           brk_ch_sel, take_action_tracemem, take_action_tracectrl, cap_sr, cap_valid,
           fifo_level, ovf, cmd_err
  );

endinterface

// File: rtl/nios_v2_cpu_debug_slave_cmd_engine_cmd_fifo.sv
// Synchronous FIFO for queued scan updates; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module nios_v2_debug_cmd_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     level_o
);
  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_q <= level_q + 1'b1;
      else if (!push_ok && pop_ok) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/nios_v2_cpu_debug_slave_cmd_engine.sv
// Command engine: queues JTAG scan updates, issues one registered action pulse per popped
// command when the debug target is ready, and builds the capture word for the next scan.
module nios_v2_cpu_debug_slave_cmd_engine
  import nios_v2_debug_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TRACE_W    = 36,
  parameter int unsigned NUM_DBRK   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic clk_i,
  input logic reset_i,
  nios_v2_cpu_debug_slave_cmd_engine_if.slave dbg_io
);
  localparam int unsigned SR_W  = sr_width(DATA_W);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = IR_W + SR_W;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [ENT_W-1:0]    head;
  logic [IR_W-1:0]     head_ir;
  logic [SR_W-1:0]     head_sr;
  logic [LVL_W-1:0]    level;
  logic [1:0]          op;
  logic                act;
  logic [ChW-1:0]      ch;

  act_pulse_t          act_d, act_q;
  logic [NUM_DBRK-1:0] sel_d, sel_q;
  logic [SR_W-1:0]     jdo_d, jdo_q, cap_sr_d, cap_sr_q;
  logic                cap_valid_q, ovf_d, ovf_q, cmd_err_d, cmd_err_q, cmd_err_set, ovf_set;
  logic [DATA_W+3:0]   trace_ext;
  logic [5:0]          dbrk_ext;
  logic [DATA_W-1:0]   lvl_ext;

  assign fifo_pop          = !fifo_empty && dbg_io.tgt_ready;
  assign {head_ir, head_sr} = head;
  assign op                = head_sr[DATA_W+OpOfs +: 2];
  assign act               = head_sr[DATA_W+ActOfs];
  assign ch                = head_sr[DATA_W+ChOfs +: ChW];

  nios_v2_debug_cmd_fifo #(
    .Width (ENT_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (dbg_io.upd_pulse),
    .data_i  ({dbg_io.upd_ir, dbg_io.upd_sr}),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_comb begin
    act_d       = '0;
    sel_d       = '0;
    cmd_err_set = 1'b0;
    jdo_d       = jdo_q;
    if (fifo_pop) begin
      jdo_d = head_sr;
      unique case (head_ir)
        IrOcimem: begin
          if (act)        act_d.ocimem_a    = 1'b1;
          else if (op[0]) act_d.ocimem_b    = 1'b1;
          else            act_d.no_ocimem_a = 1'b1;
        end
        IrTracemem:  act_d.tracemem  = 1'b1;
        IrTracectrl: act_d.tracectrl = 1'b1;
        IrBreak: begin
          // Illegal op or out-of-range channel: consumed and flagged, but no pulse.
          if (op == OpIllegal || 32'(ch) >= NUM_DBRK) begin
            cmd_err_set = 1'b1;
          end else begin
            sel_d = NUM_DBRK'(1) << ch;
            unique case (op)
              OpBrkA:  begin act_d.break_a = act; act_d.no_break_a = !act; end
              OpBrkB:  begin act_d.break_b = act; act_d.no_break_b = !act; end
              default: begin act_d.break_c = act; act_d.no_break_c = !act; end
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    trace_ext                = '0;
    trace_ext[TRACE_W-1:0]   = dbg_io.trace_data;
    dbrk_ext                 = '0;
    dbrk_ext[NUM_DBRK-1:0]   = dbg_io.dbrk_hit;
    lvl_ext                  = '0;
    lvl_ext[LVL_W-1:0]       = level;
    cap_sr_d                 = cap_sr_q;
    if (dbg_io.cap_pulse) begin
      unique case (dbg_io.cap_ir)
        IrOcimem:    cap_sr_d = {ovf_q, dbg_io.mon_status, 1'b0, dbg_io.mon_data};
        IrTracemem:  cap_sr_d = {dbg_io.trace_stat, trace_ext};
        IrBreak:     cap_sr_d = {dbrk_ext, dbg_io.brk_readreg};
        IrTracectrl: cap_sr_d = {ovf_q, cmd_err_q, 4'b0, lvl_ext};
      endcase
    end
    // Setting a sticky flag takes priority over the capture that clears it.
    ovf_set   = dbg_io.upd_pulse && fifo_full && !fifo_pop;
    ovf_d     = ovf_set | (ovf_q & ~(dbg_io.cap_pulse && dbg_io.cap_ir == IrOcimem));
    cmd_err_d = cmd_err_set | (cmd_err_q & ~(dbg_io.cap_pulse && dbg_io.cap_ir == IrTracectrl));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      act_q       <= '0;
      sel_q       <= '0;
      jdo_q       <= '0;
      cap_sr_q    <= '0;
      cap_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      act_q       <= act_d;
      sel_q       <= sel_d;
      jdo_q       <= jdo_d;
      cap_sr_q    <= cap_sr_d;
      cap_valid_q <= dbg_io.cap_pulse;
      ovf_q       <= ovf_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign dbg_io.jdo                     = jdo_q;
  assign dbg_io.take_action_ocimem_a    = act_q.ocimem_a;
  assign dbg_io.take_action_ocimem_b    = act_q.ocimem_b;
  assign dbg_io.take_no_action_ocimem_a = act_q.no_ocimem_a;
  assign dbg_io.take_action_break_a     = act_q.break_a;
  assign dbg_io.take_action_break_b     = act_q.break_b;
  assign dbg_io.take_action_break_c     = act_q.break_c;
  assign dbg_io.take_no_action_break_a  = act_q.no_break_a;
  assign dbg_io.take_no_action_break_b  = act_q.no_break_b;
  assign dbg_io.take_no_action_break_c  = act_q.no_break_c;
  assign dbg_io.brk_ch_sel              = sel_q;
  assign dbg_io.take_action_tracemem    = act_q.tracemem;
  assign dbg_io.take_action_tracectrl   = act_q.tracectrl;
  assign dbg_io.cap_sr                  = cap_sr_q;
  assign dbg_io.cap_valid               = cap_valid_q;
  assign dbg_io.fifo_level              = level;
  assign dbg_io.ovf                     = ovf_q;
  assign dbg_io.cmd_err                 = cmd_err_q;

endmodule

// File: tb/tb_nios_v2_cpu_debug_slave_cmd_engine.sv
// Directed bench for the debug slave command engine with hand-computed expected values.
module tb_nios_v2_cpu_debug_slave_cmd_engine;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  nios_v2_cpu_debug_slave_cmd_engine_if #(
    .DATA_W(32), .TRACE_W(36), .NUM_DBRK(4), .FIFO_DEPTH(4)
  ) dbg ();

  nios_v2_cpu_debug_slave_cmd_engine #(
    .DATA_W(32), .TRACE_W(36), .NUM_DBRK(4), .FIFO_DEPTH(4)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .dbg_io  (dbg)
  );

  // Pulse vector order: oci_a, oci_b, no_oci_a, brk_a/b/c, no_brk_a/b/c, tracemem, tracectrl.
  localparam logic [10:0] P_NONE   = 11'd0;
  localparam logic [10:0] P_OCI_A  = 11'b100_0000_0000;
  localparam logic [10:0] P_OCI_B  = 11'b010_0000_0000;
  localparam logic [10:0] P_NOCI_A = 11'b001_0000_0000;
  localparam logic [10:0] P_BRK_B  = 11'b000_0100_0000;
  localparam logic [10:0] P_BRK_C  = 11'b000_0010_0000;
  localparam logic [10:0] P_NBRK_A = 11'b000_0001_0000;
  localparam logic [10:0] P_TMEM   = 11'b000_0000_0010;
  localparam logic [10:0] P_TCTRL  = 11'b000_0000_0001;

  logic [10:0] pulses;
  assign pulses = {dbg.take_action_ocimem_a, dbg.take_action_ocimem_b,
                   dbg.take_no_action_ocimem_a, dbg.take_action_break_a,
                   dbg.take_action_break_b, dbg.take_action_break_c,
                   dbg.take_no_action_break_a, dbg.take_no_action_break_b,
                   dbg.take_no_action_break_c, dbg.take_action_tracemem,
                   dbg.take_action_tracectrl};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [1:0] ir, input logic [37:0] sr);
    dbg.upd_pulse = 1'b1;
    dbg.upd_ir    = ir;
    dbg.upd_sr    = sr;
    tick();
    dbg.upd_pulse = 1'b0;
  endtask

  task automatic cap(input logic [1:0] ir);
    dbg.cap_pulse = 1'b1;
    dbg.cap_ir    = ir;
    tick();
    dbg.cap_pulse = 1'b0;
  endtask

  logic [37:0] rel_exp [4];

  initial begin
    reset = 1'b1;
    dbg.upd_pulse = 1'b0; dbg.upd_ir = '0; dbg.upd_sr = '0; dbg.tgt_ready = 1'b0;
    dbg.cap_pulse = 1'b0; dbg.cap_ir = '0; dbg.mon_data = '0; dbg.mon_status = '0;
    dbg.brk_readreg = '0; dbg.dbrk_hit = '0; dbg.trace_data = '0; dbg.trace_stat = '0;
    tick(); tick();
    reset = 1'b0;

    check("rst_level", 64'(dbg.fifo_level), 64'd0);
    check("rst_pulses", 64'(pulses), 64'(P_NONE));
    check("rst_flags", 64'({dbg.ovf, dbg.cmd_err, dbg.cap_valid}), 64'd0);
    check("rst_jdo", 64'(dbg.jdo), 64'd0);
    check("rst_cap_sr", 64'(dbg.cap_sr), 64'd0);
    check("rst_sel", 64'(dbg.brk_ch_sel), 64'd0);

    // IR0 act=1: pulse exactly at N+2 for one cycle.
    dbg.tgt_ready = 1'b1;
    upd(2'd0, 38'h08_1234_5678);
    check("oci_a_n1", 64'(pulses), 64'(P_NONE));
    tick();
    check("oci_a_n2", 64'(pulses), 64'(P_OCI_A));
    check("oci_a_jdo", 64'(dbg.jdo), 64'h08_1234_5678);
    tick();
    check("oci_a_n3", 64'(pulses), 64'(P_NONE));
    check("jdo_hold", 64'(dbg.jdo), 64'h08_1234_5678);

    upd(2'd0, 38'h10_0000_0001); tick();
    check("oci_b", 64'(pulses), 64'(P_OCI_B));
    upd(2'd0, 38'h00_0000_0002); tick();
    check("no_oci_a", 64'(pulses), 64'(P_NOCI_A));
    upd(2'd1, 38'h00_0000_0003); tick();
    check("tracemem", 64'(pulses), 64'(P_TMEM));
    upd(2'd3, 38'h00_0000_0004); tick();
    check("tracectrl", 64'(pulses), 64'(P_TCTRL));

    // IR2 break commands.
    upd(2'd2, 38'h1B_0000_00AA); tick();
    check("brk_b", 64'(pulses), 64'(P_BRK_B));
    check("brk_b_sel", 64'(dbg.brk_ch_sel), 64'b1000);
    check("brk_b_err", 64'(dbg.cmd_err), 64'd0);
    upd(2'd2, 38'h01_0000_0000); tick();
    check("nbrk_a", 64'(pulses), 64'(P_NBRK_A));
    check("nbrk_a_sel", 64'(dbg.brk_ch_sel), 64'b0010);
    upd(2'd2, 38'h28_0000_0000); tick();
    check("brk_c", 64'(pulses), 64'(P_BRK_C));
    check("brk_c_sel", 64'(dbg.brk_ch_sel), 64'b0001);
    upd(2'd2, 38'h1D_0000_0055); tick();
    check("ch5_pulse", 64'(pulses), 64'(P_NONE));
    check("ch5_err", 64'(dbg.cmd_err), 64'd1);
    check("ch5_jdo", 64'(dbg.jdo), 64'h1D_0000_0055);
    check("ch5_level", 64'(dbg.fifo_level), 64'd0);

    // IR3 capture reports then clears cmd_err.
    cap(2'd3);
    check("cap3_valid", 64'(dbg.cap_valid), 64'd1);
    check("cap3_sr", 64'(dbg.cap_sr), 64'h10_0000_0000);
    check("cap3_clr", 64'(dbg.cmd_err), 64'd0);
    tick();
    check("cap_valid_1cyc", 64'(dbg.cap_valid), 64'd0);

    upd(2'd2, 38'h38_0000_0000); tick();
    check("op3_pulse", 64'(pulses), 64'(P_NONE));
    check("op3_err", 64'(dbg.cmd_err), 64'd1);

    // Overflow: five updates into a depth-4 FIFO with target stalled.
    dbg.tgt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dbg.upd_pulse = 1'b1; dbg.upd_ir = 2'd1; dbg.upd_sr = 38'(i + 1);
      tick();
    end
    dbg.upd_pulse = 1'b0;
    check("ovf_level", 64'(dbg.fifo_level), 64'd4);
    check("ovf_set", 64'(dbg.ovf), 64'd1);
    check("stall_pulse", 64'(pulses), 64'(P_NONE));

    // Overflow and IR0 capture in the same cycle: set wins.
    dbg.mon_data = 32'hDEAD_BEEF; dbg.mon_status = 4'hA;
    dbg.upd_pulse = 1'b1; dbg.upd_sr = 38'h2A;
    cap(2'd0);
    dbg.upd_pulse = 1'b0;
    check("ovf_set_wins", 64'(dbg.ovf), 64'd1);

    // Full FIFO, push and pop together.
    dbg.tgt_ready = 1'b1; dbg.upd_pulse = 1'b1; dbg.upd_ir = 2'd1; dbg.upd_sr = 38'h3F;
    tick();
    dbg.upd_pulse = 1'b0; dbg.tgt_ready = 1'b0;
    check("fullpop_level", 64'(dbg.fifo_level), 64'd4);
    check("fullpop_ovf", 64'(dbg.ovf), 64'd1);
    check("fullpop_pulse", 64'(pulses), 64'(P_TMEM));
    check("fullpop_jdo", 64'(dbg.jdo), 64'd1);

    cap(2'd0);
    check("cap0_sr", 64'(dbg.cap_sr), 64'h34_DEAD_BEEF);
    check("cap0_ovf_clr", 64'(dbg.ovf), 64'd0);

    // Release: four consecutive pulses.
    rel_exp[0] = 38'd2; rel_exp[1] = 38'd3; rel_exp[2] = 38'd4; rel_exp[3] = 38'h3F;
    dbg.tgt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rel_pulse%0d", i), 64'(pulses), 64'(P_TMEM));
      check($sformatf("rel_jdo%0d", i), 64'(dbg.jdo), 64'(rel_exp[i]));
    end
    tick();
    check("rel_done_pulse", 64'(pulses), 64'(P_NONE));
    check("rel_done_level", 64'(dbg.fifo_level), 64'd0);

    // IR1 and IR2 captures.
    dbg.trace_data = 36'h9_8765_4321; dbg.trace_stat = 2'b10;
    cap(2'd1);
    check("cap1_sr", 64'(dbg.cap_sr), 64'h29_8765_4321);
    dbg.dbrk_hit = 4'b0101; dbg.brk_readreg = 32'hCAFE_F00D;
    cap(2'd2);
    check("cap2_sr", 64'(dbg.cap_sr), 64'h05_CAFE_F00D);

    // Reset with queued entries and a pulse in flight.
    dbg.tgt_ready = 1'b0;
    for (int i = 0; i < 3; i++) upd(2'd0, 38'h08_0000_0000);
    check("q3_level", 64'(dbg.fifo_level), 64'd3);
    dbg.tgt_ready = 1'b1;
    tick();
    check("q3_pulse", 64'(pulses), 64'(P_OCI_A));
    check("q3_level2", 64'(dbg.fifo_level), 64'd2);
    reset = 1'b1;
    tick();
    check("rst_mid_pulse", 64'(pulses), 64'(P_NONE));
    check("rst_mid_level", 64'(dbg.fifo_level), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_pulse%0d", i), 64'(pulses), 64'(P_NONE));
      check($sformatf("post_rst_level%0d", i), 64'(dbg.fifo_level), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
